// File: rtl/rom_stream_reader_pkg.sv
// rtl/rom_stream_reader_pkg.sv - shared FSM encodings and FIFO sizing
package rom_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_stream_reader_fifo.sv
// rtl/rom_stream_reader_fifo.sv - 2-entry synchronous FIFO with registered head
module stream_fifo2
  import rom_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_valid,
  output logic [1:0]            o_count
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] tail;

  assign o_valid = (o_count != 2'd0);

  // Head is always a register so the consumer never sees a mux from i_pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_head  <= '0;
      tail    <= '0;
      o_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (o_count == 2'd0) o_head <= i_push_data;
          else                 tail   <= i_push_data;
          o_count <= o_count + 2'd1;
        end
        2'b01: begin
          o_head  <= tail;
          o_count <= o_count - 2'd1;
        end
        2'b11: begin
          if (o_count == FULL) begin
            o_head <= tail;
            tail   <= i_push_data;
          end else begin
            o_head <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - walks a ROM address range and streams the words out
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  issue_rem;
  logic [LEN_WIDTH-1:0]  beat_rem;
  logic                  inflight;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic                  issue;
  logic                  load;

  assign pop   = o_valid & i_ready;
  assign load  = (state == ST_IDLE) && i_start && (i_length != '0);
  // A pop this cycle frees a slot, so issuing keeps 1 word/cycle under full flow.
  assign issue = (state == ST_RUN) && (issue_rem != '0) &&
                 ((({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2) || pop);
  assign o_last = o_valid && (beat_rem == LEN_ONE);

  stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (inflight),
    .i_push_data (i_rom_data),
    .i_pop       (pop),
    .o_head      (o_data),
    .o_valid     (o_valid),
    .o_count     (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    o_busy    = (state != ST_IDLE);
    o_done    = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = (i_length != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (pop && o_last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      o_rom_addr <= '0;
      issue_rem  <= '0;
      beat_rem   <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (load) begin
        o_rom_addr <= i_start_addr;
        issue_rem  <= i_length;
        beat_rem   <= i_length;
      end else begin
        if (issue) begin
          o_rom_addr <= o_rom_addr + ADDR_ONE;
          issue_rem  <= issue_rem - LEN_ONE;
        end
        if (pop) beat_rem <= beat_rem - LEN_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - scoreboard bench for rom_stream_reader
module tb_rom_stream_reader;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic [7:0] i_start_addr;
  logic [8:0] i_length;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_rom_addr;
  logic [7:0] i_rom_data;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;
  logic       i_ready;

  int n_checks;
  int n_fails;
  int pops;
  logic [8:0] sb_q[$];
  logic       hold_pending;
  logic [7:0] hold_data;

  rom_stream_reader dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_start_addr (i_start_addr),
    .i_length     (i_length),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (i_rom_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .i_ready      (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous ROM model: mem[i] = i ^ 0xA5, one-cycle read latency.
  always @(posedge i_clk) i_rom_data <= o_rom_addr ^ 8'hA5;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hold_pending = 1'b0;
    end else begin
      check("fifo_count_le2", 32'(dut.fifo_count <= 2'd2), 32'd1);
      if (hold_pending) begin
        check("stall_valid_held", 32'(o_valid), 32'd1);
        check("stall_data_held", 32'(o_data), 32'(hold_data));
      end
      if (o_valid && i_ready) begin
        pops++;
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(o_data), 32'hFFFF);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          check("beat_data", 32'(o_data), 32'(e[7:0]));
          check("beat_last", 32'(o_last), 32'(e[8]));
        end
      end
      hold_pending = o_valid && !i_ready;
      hold_data    = o_data;
    end
  end

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  task automatic push_expected(input logic [7:0] addr, input int len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] a;
      a = addr + 8'(i);
      sb_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, a ^ 8'hA5});
    end
  endtask

  task automatic run_burst(input logic [7:0] addr, input int len, input int mode, input bit poke);
    int cyc, first_v, done_c;
    push_expected(addr, len);
    i_start_addr = addr;
    i_length     = 9'(len);
    i_start      = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1; first_v = 0; done_c = 0;
    i_ready = ready_for(mode, cyc);
    while (cyc < 2000) begin
      @(negedge i_clk);
      if (cyc == 1) check("busy_after_start", 32'(o_busy), 32'd1);
      if (o_valid && first_v == 0) first_v = cyc;
      if (o_done) begin
        done_c = cyc;
        break;
      end
      @(posedge i_clk); #1;
      cyc++;
      i_ready = ready_for(mode, cyc);
      if (poke) begin
        i_start      = (cyc == 4);
        i_start_addr = 8'h80;
        i_length     = 9'd3;
      end
    end
    i_start = 1'b0;
    check("done_seen", 32'(done_c != 0), 32'd1);
    if (mode == 0) check("done_cycle", 32'(done_c), (len == 0) ? 32'd1 : 32'(len + 3));
    if (len > 0) check("first_valid_cycle", 32'(first_v), 32'd3);
    else         check("no_valid_len0", 32'(first_v), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("idle_after_done", {29'd0, o_busy, o_done, o_valid}, 32'd0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("no_extra_burst", {30'd0, o_busy, o_valid}, 32'd0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    n_checks = 0; n_fails = 0; pops = 0;
    hold_pending = 1'b0; hold_data = '0;
    i_rst_n = 1'b0; i_start = 1'b0; i_start_addr = '0; i_length = '0; i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_outputs", {26'd0, o_valid, o_last, o_busy, o_done, 2'b00}, 32'd0);
    check("reset_data_addr", {16'd0, o_data, o_rom_addr}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    run_burst(8'h10, 4, 0, 1'b0);
    run_burst(8'h30, 8, 1, 1'b0);
    run_burst(8'hFE, 4, 0, 1'b0);
    run_burst(8'h00, 0, 0, 1'b0);
    run_burst(8'h00, 256, 0, 1'b0);
    run_burst(8'h50, 6, 0, 1'b1);

    // Reset in the middle of a stalled burst.
    pops = 0;
    push_expected(8'h20, 8);
    i_start_addr = 8'h20; i_length = 9'd8; i_start = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 50 && pops < 3; k++) begin
      @(posedge i_clk); #1;
    end
    check("reset_pre_beats", 32'(pops), 32'd3);
    i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("midreset_outputs", {26'd0, o_valid, o_last, o_busy, o_done, 2'b00}, 32'd0);
    check("midreset_data_addr", {16'd0, o_data, o_rom_addr}, 32'd0);
    sb_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_burst(8'h40, 2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Address sequencer and stream adapter that sits directly upstream of the team's synchronous ROM (one-cycle read latency) and consumes its data.
- On a start command it walks a contiguous address range and presents the words on a valid/ready output stream, with o_last on the final word.
- Typical uses: message strings to the UART TX, waveform tables to a DAC/PWM, sprite rows to a display.
- Absorbs the ROM latency and downstream backpressure without losing or duplicating words.

Parameters:
- ADDR_WIDTH, 8, ROM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, ROM word width.
- LEN_WIDTH, ADDR_WIDTH+1, width of the length field; allows the full 2^ADDR_WIDTH-word range.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_start_addr  in  ADDR_WIDTH  first address of the burst.
- i_length  in  LEN_WIDTH  number of words in the burst.
- o_busy  out  1  high from the cycle after start is accepted until the done pulse.
- o_done  out  1  one-cycle pulse when the burst completes.
- o_rom_addr  out  ADDR_WIDTH  registered address to the ROM.
- i_rom_data  in  DATA_WIDTH  ROM read data; valid one cycle after o_rom_addr is sampled.
- o_data  out  DATA_WIDTH  stream data.
- o_valid  out  1  stream valid.
- o_last  out  1  qualifies the final word of the burst; meaningful only while o_valid=1.
- i_ready  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, any state, including mid-burst): state=IDLE, o_rom_addr=0, o_data=0, o_valid=0, o_last=0, o_busy=0, o_done=0. FIFO emptied, in-flight flag cleared, counters cleared. No stale word may appear after reset release.
- FSM states:
  - IDLE: i_start=1 with i_length>0 loads the address register with i_start_addr, loads issue and beat counters with i_length, goes to RUN. i_start=1 with i_length=0 goes to DONE with no beats.
  - RUN: issues reads and drains the FIFO. Goes to DONE on the edge where the final beat handshakes (o_valid & i_ready & o_last).
  - DONE: o_done=1 for one cycle, then IDLE.
- i_start is ignored outside IDLE.
- o_busy=1 in RUN and DONE.
- Issue rule:
  - One read is issued at each edge in RUN where issue_remaining>0 and (fifo_count + inflight < 2, or a stream pop occurs in the same cycle).
  - On issue: inflight<=1, o_rom_addr<=o_rom_addr+1 (wraps 2^ADDR_WIDTH-1 -> 0), issue_remaining decrements. Otherwise inflight<=0 and the address holds.
- Capture: in any cycle with inflight=1, i_rom_data is pushed into the 2-entry FIFO at the next edge.
- Output: o_valid is FIFO non-empty and o_data is the FIFO head. Registered outputs only; no combinational path from i_ready to o_valid/o_data.
- o_last=1 while the head word is the final beat (beat_remaining==1).
- Simultaneous push and pop at fifo_count=1 or 2 leaves the count unchanged.
- Overflow is impossible by construction. The bench asserts fifo_count<=2.
- Timing:
  - Start sampled at edge 0: o_rom_addr=A during cycle 1, i_rom_data=D[A] during cycle 2, o_valid=1 from cycle 3.
  - With i_ready held high, throughput is 1 word/cycle.
  - For length L, the last beat handshakes in cycle L+2, o_done is high in cycle L+3, and IDLE is entered at edge L+4.
- Backpressure:
  - With i_ready=0, at most 2 words are buffered and issue stalls.
  - The held o_data and o_valid stay stable until a handshake.

Decomposition:
- Shared header: FSM state encodings (ST_IDLE, ST_RUN, ST_DONE) as localparams.
- Sub-module stream_fifo2: 2-entry synchronous FIFO with registered head, count output, async active-low reset; reusable elsewhere.
- Address, counter and FSM logic stay in rom_stream_reader.

Test Plan:
- Burst, no stall: start addr=0x10, len=4, i_ready=1, backed by rom_sync with mem[i]=i^0xA5 -> beats 0xB5,0xB4,0xB7,0xB6 in cycles 3..6, o_last only on 0xB6, o_done in cycle 7.
- Backpressure: len=8, i_ready toggles 1,0,0,1 repeating -> all 8 words in order with none dropped or repeated, o_data stable while stalled, fifo_count<=2 throughout.
- Wrap-around: addr=0xFE, len=4 -> words from addresses 0xFE,0xFF,0x00,0x01.
- Length edges: len=0 -> no o_valid, o_done one cycle after start. len=256 -> 256 beats, o_last on beat 256 only.
- Ignored start: i_start pulsed mid-burst with a different address -> current burst unaffected, no second burst.
- Reset mid-burst: assert i_rst_n=0 after 3 beats with i_ready=0 -> all outputs 0 immediately. After release, a new burst (addr=0x40, len=2) yields exactly D[0x40], D[0x41].
